// File: rtl/ddr2_chk_pkg.sv
// ddr2_chk_pkg: FSM encoding, pattern modes and default pattern shared by the DDR2 read checker.
package ddr2_chk_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_GRANT, PRE_XFR, DATA_XFR, NEXT} chk_state_t;
    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INCR = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [31:0] DEFAULT_PATTERN = 32'hFDCB8610;
endpackage

// File: rtl/ddr2_chk_pattern_gen.sv
// ddr2_chk_pattern_gen: expected-word generator, registered so the word for the
// current beat is ready in the cycle the beat arrives.
module ddr2_chk_pattern_gen
    import ddr2_chk_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [9:0]        beat,
    output logic [DATA_W-1:0] expected
);
    logic [DATA_W-1:0] word;

    always_comb
        word = mode == MODE_INCR ? PATTERN + DATA_W'(beat) :
               (mode == MODE_CHECKER && beat[0]) ? ~PATTERN : PATTERN;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            expected <= PATTERN;
        else
            expected <= word;
endmodule

// File: rtl/ddr2_rd_checker.sv
// ddr2_rd_checker: read-traffic master that walks frame-buffer rows and checks every returned beat.
// Define RD_CHECKER_TIMEOUT_EN to add a stall watchdog and the timeout_fault output.
module ddr2_rd_checker
    import ddr2_chk_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROW_W = 13,
    parameter int COL_W = 10,
    parameter int BANK_W = 2,
    parameter logic [9:0] XFR_LEN = 10'h200,
    parameter logic [ROW_W-1:0] MAX_ROW = ROW_W'('h02FF),
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN),
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           clr,
    input  logic [1:0]                     mode,
    output logic                           rd_mem_req,
    output logic [ROW_W+COL_W+BANK_W-1:0]  rd_mem_addr,
    output logic [9:0]                     rd_xfr_len,
    input  logic                           rd_mem_grant,
    input  logic [DATA_W-1:0]              rd_data,
    input  logic                           rd_data_valid,
    output logic                           busy,
    output logic                           data_fault,
    output logic [15:0]                    err_cnt,
    output logic [ROW_W-1:0]               first_err_row,
    output logic [9:0]                     first_err_beat,
    output logic [15:0]                    screen_cnt,
    output logic                           screen_cnt_overrun,
    output logic                           len_fault
`ifdef RD_CHECKER_TIMEOUT_EN
    ,
    output logic                           timeout_fault
`endif
);
    chk_state_t state, state_n;
    logic [ROW_W-1:0] row;
    logic [9:0] beat, beat_n;
    logic [1:0] mode_q, mode_n;
    logic stop_seen;
    logic [DATA_W-1:0] expected;
    logic [15:0] err_base;
    logic accept, in_xfr, chk, last, mism, wrap, stray, timeout;

    assign accept = state == IDLE && start && !stop;
    assign in_xfr = state == PRE_XFR || state == DATA_XFR;
    assign chk = rd_data_valid && in_xfr;
    assign last = beat == XFR_LEN - 10'd1;
    assign mism = chk && rd_data != expected;
    assign wrap = state == NEXT && row == MAX_ROW;
    assign stray = rd_data_valid && !in_xfr;
    assign mode_n = accept ? mode : mode_q;
    assign beat_n = chk ? beat + 10'd1 : in_xfr ? beat : 10'd0;
    assign err_base = clr ? 16'd0 : err_cnt;

    assign busy = state != IDLE;
    assign rd_mem_req = state == WAIT_GRANT;
    assign rd_xfr_len = rd_mem_req ? XFR_LEN : 10'd0;
    assign rd_mem_addr = {row, {COL_W{1'b0}}, {BANK_W{1'b0}}};

    // Fed with next-cycle mode/beat so its registered word lines up with the arriving beat.
    ddr2_chk_pattern_gen #(
        .DATA_W (DATA_W),
        .PATTERN(PATTERN)
    ) u_pattern_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode_n),
        .beat    (beat_n),
        .expected(expected)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = accept ? WAIT_GRANT : IDLE;
            WAIT_GRANT: state_n = rd_mem_grant ? PRE_XFR : WAIT_GRANT;
            PRE_XFR:    state_n = !rd_data_valid ? PRE_XFR : last ? NEXT : DATA_XFR;
            DATA_XFR:   state_n = rd_data_valid && last ? NEXT : DATA_XFR;
            NEXT:       state_n = stop_seen || stop ? IDLE : WAIT_GRANT;
            default:    state_n = IDLE;
        endcase
        if (timeout)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            row <= '0;
            beat <= '0;
            mode_q <= MODE_CONST;
            stop_seen <= 1'b0;
        end else begin
            state <= state_n;
            beat <= beat_n;
            mode_q <= mode_n;
            stop_seen <= state != IDLE && (stop_seen || stop);
            if (state == NEXT)
                row <= wrap ? '0 : row + ROW_W'(1);
        end

    // A mismatch coinciding with clr lands on the cleared status, so it counts as a first error.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            data_fault <= 1'b0;
            err_cnt <= '0;
            first_err_row <= '0;
            first_err_beat <= '0;
            screen_cnt <= '0;
            screen_cnt_overrun <= 1'b0;
            len_fault <= 1'b0;
        end else begin
            data_fault <= (data_fault && !clr) || mism;
            err_cnt <= err_base + 16'(mism && err_base != 16'hFFFF);
            if (mism && (clr || !data_fault)) begin
                first_err_row <= row;
                first_err_beat <= beat;
            end else if (clr) begin
                first_err_row <= '0;
                first_err_beat <= '0;
            end
            screen_cnt <= (clr ? 16'd0 : screen_cnt) + 16'(wrap);
            screen_cnt_overrun <= (screen_cnt_overrun && !clr) || (wrap && !clr && screen_cnt == 16'hFFFF);
            len_fault <= (len_fault && !clr) || stray;
        end

`ifdef RD_CHECKER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
    logic stall;

    assign stall = (state == WAIT_GRANT || in_xfr) && !rd_mem_grant && !rd_data_valid;
    assign timeout = stall && wd == WD_W'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wd <= '0;
            timeout_fault <= 1'b0;
        end else begin
            wd <= stall && !timeout ? wd + WD_W'(1) : '0;
            timeout_fault <= (timeout_fault && !clr) || timeout;
        end
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_ddr2_rd_checker.sv
// tb_ddr2_rd_checker: scenario table, hand-written corner cases and randomized runs
// against a transaction-level model of the checker's status.
module tb_ddr2_rd_checker;
    localparam int XL = 4;
    localparam int MR = 2;
    localparam logic [31:0] PAT = 32'hFDCB8610;

    logic clk = 0, rst_n = 0, start = 0, stop = 0, clr = 0, grant = 0, valid = 0;
    logic [1:0] mode = 0;
    logic [31:0] rd_data = 0;
    logic req, busy, data_fault, screen_ovr, len_fault;
    logic [24:0] addr;
    logic [9:0] xlen, fbeat;
    logic [15:0] err_cnt, screen_cnt;
    logic [12:0] frow;
`ifdef RD_CHECKER_TIMEOUT_EN
    logic timeout_fault;
`endif

    int n_cmp = 0, n_bad = 0;
    int m_row, m_screen, m_err, m_frow, m_fbeat;
    bit m_fault, m_len;
    logic [1:0] cur_mode;

    typedef struct {
        logic [1:0] mode;
        int nlines, bad_line, bad_beat;
        logic [31:0] bad_val;
        int gdly, gap;
        logic fault;
        logic [15:0] err;
        logic [12:0] frow;
        logic [9:0] fbeat;
        logic [15:0] screen;
    } vec_t;
    vec_t tv[6];

    ddr2_rd_checker #(
        .XFR_LEN    (10'd4),
        .MAX_ROW    (13'd2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .stop              (stop),
        .clr               (clr),
        .mode              (mode),
        .rd_mem_req        (req),
        .rd_mem_addr       (addr),
        .rd_xfr_len        (xlen),
        .rd_mem_grant      (grant),
        .rd_data           (rd_data),
        .rd_data_valid     (valid),
        .busy              (busy),
        .data_fault        (data_fault),
        .err_cnt           (err_cnt),
        .first_err_row     (frow),
        .first_err_beat    (fbeat),
        .screen_cnt        (screen_cnt),
        .screen_cnt_overrun(screen_ovr),
        .len_fault         (len_fault)
`ifdef RD_CHECKER_TIMEOUT_EN
        ,
        .timeout_fault     (timeout_fault)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000ns");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [1:0] m, input int b);
        if (m == 2'd1) return PAT + 32'(b);
        if (m == 2'd2) return (b % 2) ? ~PAT : PAT;
        return PAT;
    endfunction

    task automatic model_clr();
        m_err = 0; m_fault = 0; m_frow = 0; m_fbeat = 0; m_screen = 0; m_len = 0;
    endtask

    task automatic model_beat(input logic [31:0] d, input int b);
        if (d != exp_word(cur_mode, b)) begin
            if (m_err < 65535) m_err++;
            if (!m_fault) begin m_frow = m_row; m_fbeat = b; end
            m_fault = 1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_fault"}, data_fault, m_fault);
        check({tag, "_err"}, err_cnt, m_err);
        check({tag, "_frow"}, frow, m_frow);
        check({tag, "_fbeat"}, fbeat, m_fbeat);
        check({tag, "_screen"}, screen_cnt, m_screen);
        check({tag, "_ovr"}, screen_ovr, 0);
        check({tag, "_len"}, len_fault, m_len);
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; stop = 0; clr = 0; valid = 0; grant = 0;
        tick;
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        check("rst_xlen", xlen, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", data_fault, 0);
        check("rst_err", err_cnt, 0);
        check("rst_screen", screen_cnt, 0);
        check("rst_len", len_fault, 0);
        tick;
        rst_n = 1;
        m_row = 0;
        model_clr();
    endtask

    task automatic start_run(input logic [1:0] m);
        mode = m; start = 1; cur_mode = m;
        tick;
        start = 0;
        mode = 2'($urandom);
        check("req_after_start", req, 1);
    endtask

    task automatic serve_line(input int bad_beat, input logic [31:0] bad_val, input int gdly,
                              input int gap, input int stop_beat, input int clr_beat);
        int w = 0, held = 1;
        while (!req && w < 100) begin tick; w++; end
        check("req_seen", req, 1);
        if (!req) return;
        check("addr", addr, {m_row[12:0], 12'd0});
        check("xfr_len", xlen, XL);
        for (int i = 0; i < gdly; i++) begin
            tick;
            if (req) held++;
        end
        check("addr_at_grant", addr, {m_row[12:0], 12'd0});
        grant = 1;
        tick;
        grant = 0;
        check("req_drop", req, 0);
        check("req_held", held, gdly + 1);
        for (int b = 0; b < XL; b++) begin
            int g;
            g = gap == 1 ? 1 : gap == 2 ? int'($urandom_range(0, 2)) : 0;
            repeat (g) tick;
            valid = 1;
            rd_data = b == bad_beat ? bad_val : exp_word(cur_mode, b);
            stop = b == stop_beat;
            clr = b == clr_beat;
            if (clr) model_clr();
            model_beat(rd_data, b);
            tick;
            valid = 0; stop = 0; clr = 0;
        end
        if (m_row == MR) begin m_row = 0; m_screen = (m_screen + 1) % 65536; end
        else m_row++;
        tick;
        if (stop_beat >= 0) begin
            check("idle_after_stop", busy, 0);
            check("no_req_after_stop", req, 0);
        end else
            check("next_req", req, 1);
    endtask

    initial begin
        int held;
        tv[0] = '{2'd0, 4, -1, 0, 32'h0, 0, 0, 1'b0, 16'd0, 13'd0, 10'd0, 16'd1};
        tv[1] = '{2'd1, 3, 1, 2, PAT + 32'd3, 0, 0, 1'b1, 16'd1, 13'd1, 10'd2, 16'd1};
        tv[2] = '{2'd2, 2, -1, 0, 32'h0, 10, 1, 1'b0, 16'd0, 13'd0, 10'd0, 16'd0};
        tv[3] = '{2'd2, 1, 0, 3, PAT, 0, 0, 1'b1, 16'd1, 13'd0, 10'd3, 16'd0};
        tv[4] = '{2'd3, 2, 1, 0, 32'h0, 2, 0, 1'b1, 16'd1, 13'd1, 10'd0, 16'd0};
        tv[5] = '{2'd1, 5, 4, 3, 32'h0, 1, 2, 1'b1, 16'd1, 13'd1, 10'd3, 16'd1};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            start_run(tv[i].mode);
            for (int l = 0; l < tv[i].nlines; l++)
                serve_line(l == tv[i].bad_line ? tv[i].bad_beat : -1, tv[i].bad_val, tv[i].gdly,
                           tv[i].gap, l == tv[i].nlines - 1 ? 1 : -1, -1);
            check($sformatf("v%0d_fault", i), data_fault, tv[i].fault);
            check($sformatf("v%0d_err", i), err_cnt, tv[i].err);
            check($sformatf("v%0d_frow", i), frow, tv[i].frow);
            check($sformatf("v%0d_fbeat", i), fbeat, tv[i].fbeat);
            check($sformatf("v%0d_screen", i), screen_cnt, tv[i].screen);
            check_status($sformatf("v%0d_model", i));
        end

        // stop mid-line of row 1, clr coinciding with a mismatch
        do_reset();
        start_run(2'd0);
        serve_line(0, 32'h1234, 0, 0, -1, -1);
        serve_line(2, 32'h0, 0, 0, 1, 2);
        check("stopclr_err", err_cnt, 1);
        check("stopclr_frow", frow, 1);
        check("stopclr_fbeat", fbeat, 2);
        check_status("stopclr");

        // stray beat in IDLE
        valid = 1; rd_data = 32'hDEAD;
        tick;
        valid = 0;
        m_len = 1;
        check("stray_len", len_fault, 1);
        check("stray_err", err_cnt, 1);

        // stop beats start; then resume from the row where the run stopped
        start = 1; stop = 1;
        tick;
        start = 0; stop = 0;
        tick;
        check("stop_beats_start", busy, 0);
        clr = 1;
        tick;
        clr = 0;
        model_clr();
        check_status("clr_idle");
        start_run(2'd2);
        serve_line(-1, 0, 1, 0, 0, -1);
        check_status("resume");

        // randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            int nl;
            nl = $urandom_range(1, 6);
            start_run(2'($urandom));
            for (int l = 0; l < nl; l++)
                serve_line($urandom_range(0, 2) == 0 ? int'($urandom_range(0, XL - 1)) : -1, $urandom,
                           $urandom_range(0, 4), 2, l == nl - 1 ? int'($urandom_range(0, XL - 1)) : -1,
                           $urandom_range(0, 5) == 0 ? int'($urandom_range(0, XL - 1)) : -1);
            check_status($sformatf("rnd%0d", r));
            if ($urandom_range(0, 3) == 0) begin
                clr = 1;
                tick;
                clr = 0;
                model_clr();
            end
        end

`ifdef RD_CHECKER_TIMEOUT_EN
        do_reset();
        start_run(2'd0);
        held = 0;
        while (req && held < 40) begin held++; tick; end
        check("wd_req_cycles", held, 16);
        check("wd_busy", busy, 0);
        check("wd_fault", timeout_fault, 1);
        clr = 1;
        tick;
        clr = 0;
        check("wd_clr", timeout_fault, 0);
`else
        held = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
